mem_wb_stage: RTL and testbench

Pipeline register between the memory-access stage and the register file, forming the write-back stage of the five-stage core. It captures the MEM-stage result each cycle, honours stall and flush, and aligns and sign- or zero-extends load data. It also detects misaligned loads. Its outputs drive the register-file write port (`we`/`waddr`/`wdata`) and the HI/LO write path.

---
 rtl/mem_wb_stage.sv | 128 ++++++++++++
 tb/tb_mem_wb_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the MEM-stage result, honours stall/flush,
// and performs big-endian load extraction plus misaligned-load detection.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_ldtype,
  input  logic [1:0]        mem_addr_lo,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_adel
);

  localparam logic [2:0] LdLb  = 3'b001;
  localparam logic [2:0] LdLbu = 3'b010;
  localparam logic [2:0] LdLh  = 3'b011;
  localparam logic [2:0] LdLhu = 3'b100;

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              is_load;
    logic [2:0]        ldtype;
    logic [1:0]        addr_lo;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } wb_regs_t;

  wb_regs_t regs_d, regs_q;

  // A held MEM stage with a running WB stage injects a bubble so the same
  // instruction is never written back twice.
  always_comb begin
    regs_d = regs_q;
    if (flush) begin
      regs_d = '0;
    end else if (stall_mem && !stall_wb) begin
      regs_d = '0;
    end else if (!stall_mem) begin
      regs_d.wd      = mem_wd;
      regs_d.wreg    = mem_wreg;
      regs_d.wdata   = mem_wdata;
      regs_d.is_load = mem_is_load;
      regs_d.ldtype  = mem_ldtype;
      regs_d.addr_lo = mem_addr_lo;
      regs_d.whilo   = mem_whilo;
      regs_d.hi      = mem_hi;
      regs_d.lo      = mem_lo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;
  logic              misaligned;

  always_comb begin
    // Offset 0 addresses the most significant byte (big-endian).
    unique case (regs_q.addr_lo)
      2'd0:    byte_sel = regs_q.wdata[DATA_W-1  -: 8];
      2'd1:    byte_sel = regs_q.wdata[DATA_W-9  -: 8];
      2'd2:    byte_sel = regs_q.wdata[DATA_W-17 -: 8];
      default: byte_sel = regs_q.wdata[DATA_W-25 -: 8];
    endcase
    half_sel = regs_q.addr_lo[1] ? regs_q.wdata[DATA_W-17 -: 16]
                                 : regs_q.wdata[DATA_W-1  -: 16];

    load_data  = regs_q.wdata;
    misaligned = 1'b0;
    case (regs_q.ldtype)
      LdLb:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LdLbu: load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LdLh: begin
        load_data  = {{(DATA_W-16){half_sel[15]}}, half_sel};
        misaligned = regs_q.addr_lo[0];
      end
      LdLhu: begin
        load_data  = {{(DATA_W-16){1'b0}}, half_sel};
        misaligned = regs_q.addr_lo[0];
      end
      // LW and the reserved encodings pass the word through.
      default: misaligned = (regs_q.addr_lo != 2'd0);
    endcase
  end

  always_comb begin
    wb_wd    = regs_q.wd;
    wb_whilo = regs_q.whilo;
    wb_hi    = regs_q.hi;
    wb_lo    = regs_q.lo;
    wb_adel  = regs_q.is_load && misaligned;
    wb_wreg  = regs_q.wreg && !wb_adel;
    if (!regs_q.is_load) begin
      wb_wdata = regs_q.wdata;
    end else if (misaligned) begin
      wb_wdata = '0;
    end else begin
      wb_wdata = load_data;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall_mem, stall_wb, flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_is_load;
  logic [2:0]  mem_ldtype;
  logic [1:0]  mem_addr_lo;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi, wb_lo;
  logic        wb_adel;

  int n_checks = 0;
  int n_errors = 0;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_mem   (stall_mem),
    .stall_wb    (stall_wb),
    .flush       (flush),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_is_load (mem_is_load),
    .mem_ldtype  (mem_ldtype),
    .mem_addr_lo (mem_addr_lo),
    .mem_whilo   (mem_whilo),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
    .wb_wd       (wb_wd),
    .wb_wreg     (wb_wreg),
    .wb_wdata    (wb_wdata),
    .wb_whilo    (wb_whilo),
    .wb_hi       (wb_hi),
    .wb_lo       (wb_lo),
    .wb_adel     (wb_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] data,
                       input logic is_load, input logic [2:0] ldtype, input logic [1:0] off);
    mem_wd      = wd;
    mem_wreg    = wreg;
    mem_wdata   = data;
    mem_is_load = is_load;
    mem_ldtype  = ldtype;
    mem_addr_lo = off;
  endtask

  task automatic load(input string tag, input logic [2:0] ldtype, input logic [1:0] off,
                      input logic [31:0] data, input logic [31:0] exp_data,
                      input logic exp_adel);
    drive(5'd3, 1'b1, data, 1'b1, ldtype, off);
    cyc();
    check({tag, ".wdata"}, wb_wdata, exp_data);
    check({tag, ".adel"}, {31'd0, wb_adel}, {31'd0, exp_adel});
    check({tag, ".wreg"}, {31'd0, wb_wreg}, {31'd0, !exp_adel});
  endtask

  initial begin
    rst = 1'b0;
    stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
    drive(5'd0, 1'b0, 32'h0, 1'b0, 3'd0, 2'd0);

    // Reset
    cyc(); cyc();
    check("rst.wd", {27'd0, wb_wd}, 32'd0);
    check("rst.wreg", {31'd0, wb_wreg}, 32'd0);
    check("rst.wdata", wb_wdata, 32'd0);
    check("rst.whilo", {31'd0, wb_whilo}, 32'd0);
    check("rst.hi", wb_hi, 32'd0);
    check("rst.lo", wb_lo, 32'd0);
    check("rst.adel", {31'd0, wb_adel}, 32'd0);
    rst = 1'b1;

    // ALU result capture, one-cycle latency
    drive(5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'd0, 2'd0);
    cyc();
    check("alu.wd", {27'd0, wb_wd}, 32'd5);
    check("alu.wreg", {31'd0, wb_wreg}, 32'd1);
    check("alu.wdata", wb_wdata, 32'h1234_5678);

    // Non-load ignores ldtype/offset
    drive(5'd6, 1'b1, 32'h8765_4321, 1'b0, 3'b001, 2'd1);
    cyc();
    check("noload.wdata", wb_wdata, 32'h8765_4321);
    check("noload.adel", {31'd0, wb_adel}, 32'd0);

    // Byte loads
    load("lb0",  3'b001, 2'd0, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0);
    load("lbu0", 3'b010, 2'd0, 32'h80FF_7F01, 32'h0000_0080, 1'b0);
    load("lb1",  3'b001, 2'd1, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0);
    load("lb2",  3'b001, 2'd2, 32'h80FF_7F01, 32'h0000_007F, 1'b0);
    load("lb3",  3'b001, 2'd3, 32'h80FF_7F01, 32'h0000_0001, 1'b0);
    load("lbu1", 3'b010, 2'd1, 32'h80FF_7F01, 32'h0000_00FF, 1'b0);

    // Halfword and word loads, misalignment
    load("lh0",  3'b011, 2'd0, 32'h8001_FFFE, 32'hFFFF_8001, 1'b0);
    load("lhu2", 3'b100, 2'd2, 32'h8001_FFFE, 32'h0000_FFFE, 1'b0);
    load("lh2",  3'b011, 2'd2, 32'h8001_FFFE, 32'hFFFF_FFFE, 1'b0);
    load("lhu0", 3'b100, 2'd0, 32'h8001_FFFE, 32'h0000_8001, 1'b0);
    load("lh1",  3'b011, 2'd1, 32'h8001_FFFE, 32'h0000_0000, 1'b1);
    load("lhu3", 3'b100, 2'd3, 32'h8001_FFFE, 32'h0000_0000, 1'b1);
    load("lw0",  3'b000, 2'd0, 32'h8001_FFFE, 32'h8001_FFFE, 1'b0);
    load("lw2",  3'b000, 2'd2, 32'h8001_FFFE, 32'h0000_0000, 1'b1);
    load("rsv0", 3'b111, 2'd0, 32'h8001_FFFE, 32'h8001_FFFE, 1'b0);
    load("rsv1", 3'b101, 2'd1, 32'h8001_FFFE, 32'h0000_0000, 1'b1);

    // Stall bubble: held MEM stage must not be written back again
    drive(5'd7, 1'b1, 32'hAAAA_5555, 1'b0, 3'd0, 2'd0);
    cyc();
    check("stl.cap.wd", {27'd0, wb_wd}, 32'd7);
    stall_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stl.bub.wreg", {31'd0, wb_wreg}, 32'd0);
      check("stl.bub.wd", {27'd0, wb_wd}, 32'd0);
    end
    stall_mem = 1'b0;

    // Double stall holds a misaligned load with its adel flag
    mem_whilo = 1'b1; mem_hi = 32'h0000_0A0A; mem_lo = 32'h0000_0B0B;
    drive(5'd6, 1'b1, 32'hCAFE_F00D, 1'b1, 3'b000, 2'd1);
    cyc();
    check("hold.cap.adel", {31'd0, wb_adel}, 32'd1);
    stall_mem = 1'b1; stall_wb = 1'b1;
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
    drive(5'd1, 1'b1, 32'h1111_1111, 1'b0, 3'd0, 2'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("hold.wd", {27'd0, wb_wd}, 32'd6);
      check("hold.adel", {31'd0, wb_adel}, 32'd1);
      check("hold.wreg", {31'd0, wb_wreg}, 32'd0);
      check("hold.hi", wb_hi, 32'h0000_0A0A);
      check("hold.whilo", {31'd0, wb_whilo}, 32'd1);
    end
    stall_mem = 1'b0; stall_wb = 1'b0;

    // Flush beats stall_wb
    mem_whilo = 1'b1; mem_hi = 32'h1111_0000; mem_lo = 32'h2222_0000;
    drive(5'd9, 1'b1, 32'h0000_0099, 1'b0, 3'd0, 2'd0);
    cyc();
    check("fl.cap.whilo", {31'd0, wb_whilo}, 32'd1);
    check("fl.cap.lo", wb_lo, 32'h2222_0000);
    flush = 1'b1; stall_wb = 1'b1;
    cyc();
    check("fl.wreg", {31'd0, wb_wreg}, 32'd0);
    check("fl.whilo", {31'd0, wb_whilo}, 32'd0);
    check("fl.wd", {27'd0, wb_wd}, 32'd0);
    check("fl.hi", wb_hi, 32'd0);
    flush = 1'b0; stall_wb = 1'b0;
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;

    // Asynchronous reset between edges, then release while MEM is stalled
    drive(5'd4, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0);
    cyc();
    check("ar.cap.wreg", {31'd0, wb_wreg}, 32'd1);
    stall_mem = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("ar.wreg", {31'd0, wb_wreg}, 32'd0);
    check("ar.wdata", wb_wdata, 32'd0);
    check("ar.wd", {27'd0, wb_wd}, 32'd0);
    check("ar.adel", {31'd0, wb_adel}, 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    check("ar.rel.wreg", {31'd0, wb_wreg}, 32'd0);
    check("ar.rel.wdata", wb_wdata, 32'd0);
    stall_mem = 1'b0;
    cyc();
    check("ar.resume.wdata", wb_wdata, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
